// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster timing types, 640x480@60 defaults and the axis total helper
package vga_timing_pkg;
  typedef struct packed {
    logic [9:0] active;
    logic [9:0] fp;
    logic [9:0] sync;
    logic [9:0] bp;
  } timing_t;
  localparam timing_t H_640 = '{active: 10'd640, fp: 10'd16, sync: 10'd96, bp: 10'd48};
  localparam timing_t V_640 = '{active: 10'd480, fp: 10'd10, sync: 10'd2, bp: 10'd33};
  function automatic int total(timing_t t);
    return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
  endfunction
  localparam int H_TOTAL = total(H_640);
  localparam int V_TOTAL = total(V_640);
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster outputs (hcount, vcount, hsync, vsync, active, line_start, frame_start; fetch, fetch_x, fetch_y with VGA_PREFETCH_EN), master drives, slave reads
interface vga_timing_if;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic       line_start;
  logic       frame_start;
`ifdef VGA_PREFETCH_EN
  logic       fetch;
  logic [9:0] fetch_x;
  logic [9:0] fetch_y;
  modport master(output hcount, vcount, hsync, vsync, active, line_start, frame_start, fetch, fetch_x, fetch_y);
  modport slave(input hcount, vcount, hsync, vsync, active, line_start, frame_start, fetch, fetch_x, fetch_y);
`else
  modport master(output hcount, vcount, hsync, vsync, active, line_start, frame_start);
  modport slave(input hcount, vcount, hsync, vsync, active, line_start, frame_start);
`endif
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; clock, reset_n, run (0 clears), load (jump to START), step (advance/wrap) in; count, nxt, wrap, in_sync/in_act (phase of nxt) out
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter timing_t    T     = H_640,
  parameter logic [9:0] START = 10'd0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       run,
  input  logic       load,
  input  logic       step,
  output logic [9:0] count,
  output logic [9:0] nxt,
  output logic       wrap,
  output logic       in_sync,
  output logic       in_act
);
  localparam logic [9:0] LAST    = 10'(total(T) - 1);
  localparam logic [9:0] SYNC_LO = T.active + T.fp;
  localparam logic [9:0] SYNC_HI = SYNC_LO + T.sync;
  always_comb begin
    wrap    = count == LAST;
    nxt     = load ? START : step ? (wrap ? 10'd0 : count + 10'd1) : count;
    in_sync = nxt >= SYNC_LO && nxt < SYNC_HI;
    in_act  = nxt < T.active;
  end
  always_ff @(posedge clock) begin
    if (!reset_n || !run) count <= 10'd0;
    else count <= nxt;
  end
endmodule

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 raster generator; clock, reset_n (sync, active low), locked in; v (vga_timing_if.master) out; VGA_PREFETCH_EN adds fetch/fetch_x/fetch_y
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter timing_t H         = H_640,
  parameter timing_t V         = V_640,
  parameter logic    HSYNC_POL = 1'b0,
  parameter logic    VSYNC_POL = 1'b0,
  parameter int      PREFETCH  = 2
) (
  input logic          clock,
  input logic          reset_n,
  input logic          locked,
  vga_timing_if.master v
);
  if (total(H) > 1024 || total(V) > 1024) begin : g_bad_total
    $error("vga_timing: H_TOTAL or V_TOTAL exceeds 1024");
  end
  if (PREFETCH < 1 || PREFETCH > int'(H.fp) + int'(H.sync) + int'(H.bp)) begin : g_bad_prefetch
    $error("vga_timing: PREFETCH outside 1..horizontal blanking");
  end
  logic       run, live, go, load, unused_ok;
  logic [9:0] h_count, v_count, h_nxt, v_nxt;
  logic       h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;
  assign go   = reset_n && locked && run;
  assign load = go && !live;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      run  <= 1'b0;
      live <= 1'b0;
    end else begin
      run  <= locked;
      live <= go;
    end
  end
  vga_axis_counter #(.T(H), .START(10'd0)) u_h (
    .clock(clock), .reset_n(reset_n), .run(go), .load(load), .step(live),
    .count(h_count), .nxt(h_nxt), .wrap(h_wrap), .in_sync(h_sync), .in_act(h_act)
  );
  vga_axis_counter #(.T(V), .START(10'd0)) u_v (
    .clock(clock), .reset_n(reset_n), .run(go), .load(load), .step(live && h_wrap),
    .count(v_count), .nxt(v_nxt), .wrap(v_wrap), .in_sync(v_sync), .in_act(v_act)
  );
  assign v.hcount = h_count;
  assign v.vcount = v_count;
  always_ff @(posedge clock) begin
    if (!reset_n || !go) begin
      v.hsync       <= ~HSYNC_POL;
      v.vsync       <= ~VSYNC_POL;
      v.active      <= 1'b0;
      v.line_start  <= 1'b0;
      v.frame_start <= 1'b0;
    end else begin
      v.hsync       <= h_sync ? HSYNC_POL : ~HSYNC_POL;
      v.vsync       <= v_sync ? VSYNC_POL : ~VSYNC_POL;
      v.active      <= h_act && v_act;
      v.line_start  <= h_nxt == 10'd0;
      v.frame_start <= h_nxt == 10'd0 && v_nxt == 10'd0;
    end
  end
`ifdef VGA_PREFETCH_EN
  logic [9:0] fh_count, fv_count, fh_nxt, fv_nxt;
  logic       fh_wrap, fv_wrap, fh_sync, fv_sync, fh_act, fv_act;
  vga_axis_counter #(.T(H), .START(10'(PREFETCH))) u_fh (
    .clock(clock), .reset_n(reset_n), .run(go), .load(load), .step(live),
    .count(fh_count), .nxt(fh_nxt), .wrap(fh_wrap), .in_sync(fh_sync), .in_act(fh_act)
  );
  vga_axis_counter #(.T(V), .START(10'd0)) u_fv (
    .clock(clock), .reset_n(reset_n), .run(go), .load(load), .step(live && fh_wrap),
    .count(fv_count), .nxt(fv_nxt), .wrap(fv_wrap), .in_sync(fv_sync), .in_act(fv_act)
  );
  assign v.fetch_x = fh_count;
  assign v.fetch_y = fv_count;
  always_ff @(posedge clock) begin
    if (!reset_n || !go) v.fetch <= 1'b0;
    else v.fetch <= fh_act && fv_act;
  end
  assign unused_ok = ^{v_wrap, fh_nxt, fv_nxt, fv_wrap, fh_sync, fv_sync};
`else
  assign unused_ok = v_wrap;
`endif
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed self-checking bench for vga_timing with 640-pixel lines and a 13-line frame
module tb_vga_timing;
  import vga_timing_pkg::*;
  localparam timing_t VT = '{active: 10'd6, fp: 10'd2, sync: 10'd2, bp: 10'd3};
  localparam int HT = 800;
  localparam int VTOT = 13;
  localparam int FRAME = HT * VTOT;
  localparam logic [24:0] IDLE = {10'd0, 10'd0, 5'b11000};
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic locked = 1'b0;
  int vectors = 0;
  int errors = 0;
  logic [24:0] obs;
  vga_timing_if vif();
  vga_timing #(.H(H_640), .V(VT), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PREFETCH(2)) dut (
    .clock(clock), .reset_n(reset_n), .locked(locked), .v(vif)
  );
  always #5 clock = ~clock;
  assign obs = {vif.hcount, vif.vcount, vif.hsync, vif.vsync, vif.active, vif.line_start, vif.frame_start};
  task automatic test_reset;
    reset_n = 1'b0;
    locked = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if (obs !== IDLE) begin errors++; $display("FAIL reset_idle: got %h want %h", obs, IDLE); end
    locked = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if (obs !== IDLE) begin errors++; $display("FAIL reset_locked_idle: got %h want %h", obs, IDLE); end
`ifdef VGA_PREFETCH_EN
    vectors++;
    if ({vif.fetch, vif.fetch_x, vif.fetch_y} !== 21'd0) begin
      errors++; $display("FAIL reset_fetch_idle: got %h want 0", {vif.fetch, vif.fetch_x, vif.fetch_y});
    end
`endif
    locked = 1'b0;
  endtask
  task automatic test_startup;
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    vectors++;
    if (obs !== IDLE) begin errors++; $display("FAIL unlocked_idle: got %h want %h", obs, IDLE); end
    locked = 1'b1;
    @(negedge clock);
    vectors++;
    if (obs !== IDLE) begin errors++; $display("FAIL lock_edge_idle: got %h want %h", obs, IDLE); end
    @(negedge clock);
    vectors++;
    if (obs !== {10'd0, 10'd0, 5'b11111}) begin errors++; $display("FAIL first_pixel: got %h want %h", obs, {10'd0, 10'd0, 5'b11111}); end
    @(negedge clock);
    vectors++;
    if (obs !== {10'd1, 10'd0, 5'b11100}) begin errors++; $display("FAIL second_pixel: got %h want %h", obs, {10'd1, 10'd0, 5'b11100}); end
    repeat (798) @(negedge clock);
    vectors++;
    if (obs !== {10'd799, 10'd0, 5'b11000}) begin errors++; $display("FAIL line_end: got %h want %h", obs, {10'd799, 10'd0, 5'b11000}); end
    @(negedge clock);
    vectors++;
    if (obs !== {10'd0, 10'd1, 5'b11110}) begin errors++; $display("FAIL line1_start: got %h want %h", obs, {10'd0, 10'd1, 5'b11110}); end
  endtask
  task automatic test_full_frame;
    int n, mh, mv, pos_err, hs_err, vs_err, act_err, act_n, ls_err, fs_err;
    n = 0; pos_err = 0; hs_err = 0; vs_err = 0; act_err = 0; act_n = 0; ls_err = 0; fs_err = 0;
    while (vif.frame_start !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (vif.frame_start !== 1'b1) begin errors++; $display("FAIL frame_start_wait: got %b want 1 within %0d cycles", vif.frame_start, 2 * FRAME); end
    for (int i = 0; i < FRAME; i++) begin
      mh = i % HT;
      mv = i / HT;
      if (vif.hcount !== 10'(mh) || vif.vcount !== 10'(mv)) pos_err++;
      if (vif.hsync !== !(mh >= 656 && mh < 752)) hs_err++;
      if (vif.vsync !== !(mv >= 8 && mv < 10)) vs_err++;
      if (vif.active !== (mh < 640 && mv < 6)) act_err++;
      if (vif.active === 1'b1) act_n++;
      if (vif.line_start !== (mh == 0)) ls_err++;
      if (vif.frame_start !== (i == 0)) fs_err++;
      @(negedge clock);
    end
    vectors++;
    if (pos_err != 0) begin errors++; $display("FAIL frame_position: got %0d bad cycles want 0", pos_err); end
    vectors++;
    if (hs_err != 0) begin errors++; $display("FAIL hsync_window: got %0d bad cycles want 0", hs_err); end
    vectors++;
    if (vs_err != 0) begin errors++; $display("FAIL vsync_window: got %0d bad cycles want 0", vs_err); end
    vectors++;
    if (act_err != 0) begin errors++; $display("FAIL active_window: got %0d bad cycles want 0", act_err); end
    vectors++;
    if (act_n != 3840) begin errors++; $display("FAIL active_count: got %0d want 3840", act_n); end
    vectors++;
    if (ls_err != 0) begin errors++; $display("FAIL line_start_pulses: got %0d bad cycles want 0", ls_err); end
    vectors++;
    if (fs_err != 0) begin errors++; $display("FAIL frame_start_pulses: got %0d bad cycles want 0", fs_err); end
  endtask
  task automatic test_free_run;
    int n, mh, mv;
    n = 0; mh = 0; mv = 0;
    vectors++;
    if (obs !== {10'd0, 10'd0, 5'b11111}) begin errors++; $display("FAIL frame_wrap: got %h want %h", obs, {10'd0, 10'd0, 5'b11111}); end
    do begin
      @(negedge clock);
      n++;
      if (int'(vif.hcount) > mh) mh = int'(vif.hcount);
      if (int'(vif.vcount) > mv) mv = int'(vif.vcount);
    end while (vif.frame_start !== 1'b1 && n < 2 * FRAME);
    vectors++;
    if (n != FRAME) begin errors++; $display("FAIL frame_period: got %0d want %0d", n, FRAME); end
    vectors++;
    if (mh != 799) begin errors++; $display("FAIL hcount_max: got %0d want 799", mh); end
    vectors++;
    if (mv != 12) begin errors++; $display("FAIL vcount_max: got %0d want 12", mv); end
  endtask
  task automatic test_lock_drop;
    repeat (3500) @(negedge clock);
    vectors++;
    if (obs !== {10'd300, 10'd4, 5'b11100}) begin errors++; $display("FAIL drop_point: got %h want %h", obs, {10'd300, 10'd4, 5'b11100}); end
    locked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if (obs !== IDLE) begin errors++; $display("FAIL unlocked_%0d: got %h want %h", i, obs, IDLE); end
    end
    locked = 1'b1;
    @(negedge clock);
    vectors++;
    if (obs !== IDLE) begin errors++; $display("FAIL relock_wait: got %h want %h", obs, IDLE); end
    @(negedge clock);
    vectors++;
    if (obs !== {10'd0, 10'd0, 5'b11111}) begin errors++; $display("FAIL relock_start: got %h want %h", obs, {10'd0, 10'd0, 5'b11111}); end
  endtask
  task automatic test_reset_mid;
    repeat (4639) @(negedge clock);
    vectors++;
    if (obs !== {10'd639, 10'd5, 5'b11100}) begin errors++; $display("FAIL reset_point: got %h want %h", obs, {10'd639, 10'd5, 5'b11100}); end
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if (obs !== IDLE) begin errors++; $display("FAIL in_reset_%0d: got %h want %h", i, obs, IDLE); end
    end
    reset_n = 1'b1;
    @(negedge clock);
    vectors++;
    if (obs !== IDLE) begin errors++; $display("FAIL release_wait: got %h want %h", obs, IDLE); end
    @(negedge clock);
    vectors++;
    if (obs !== {10'd0, 10'd0, 5'b11111}) begin errors++; $display("FAIL release_start: got %h want %h", obs, {10'd0, 10'd0, 5'b11111}); end
  endtask
`ifdef VGA_PREFETCH_EN
  task automatic test_prefetch;
    int t, tx, ty, ferr, fcount;
    logic want;
    ferr = 0; fcount = 0;
    for (int i = 0; i < FRAME; i++) begin
      t = (i + 2) % FRAME;
      tx = t % HT;
      ty = t / HT;
      want = tx < 640 && ty < 6;
      if (vif.fetch !== want) ferr++;
      if (want && (vif.fetch_x !== 10'(tx) || vif.fetch_y !== 10'(ty))) ferr++;
      if (vif.fetch === 1'b1) fcount++;
      if (i == 637) begin
        vectors++;
        if ({vif.fetch, vif.fetch_x, vif.fetch_y} !== {1'b1, 10'd639, 10'd0}) begin
          errors++; $display("FAIL last_fetch: got %h want %h", {vif.fetch, vif.fetch_x, vif.fetch_y}, {1'b1, 10'd639, 10'd0});
        end
      end
      if (i == 638) begin
        vectors++;
        if (vif.fetch !== 1'b0) begin errors++; $display("FAIL fetch_gap: got %b want 0", vif.fetch); end
      end
      if (i == FRAME - 2) begin
        vectors++;
        if ({vif.hcount, vif.vcount, vif.fetch, vif.fetch_x, vif.fetch_y} !== {10'd798, 10'd12, 1'b1, 10'd0, 10'd0}) begin
          errors++; $display("FAIL fetch_798: got %h want %h", {vif.hcount, vif.vcount, vif.fetch, vif.fetch_x, vif.fetch_y}, {10'd798, 10'd12, 1'b1, 10'd0, 10'd0});
        end
      end
      if (i == FRAME - 1) begin
        vectors++;
        if ({vif.hcount, vif.vcount, vif.fetch, vif.fetch_x, vif.fetch_y} !== {10'd799, 10'd12, 1'b1, 10'd1, 10'd0}) begin
          errors++; $display("FAIL fetch_799: got %h want %h", {vif.hcount, vif.vcount, vif.fetch, vif.fetch_x, vif.fetch_y}, {10'd799, 10'd12, 1'b1, 10'd1, 10'd0});
        end
      end
      @(negedge clock);
    end
    vectors++;
    if (ferr != 0) begin errors++; $display("FAIL fetch_pattern: got %0d bad cycles want 0", ferr); end
    vectors++;
    if (fcount != 3840) begin errors++; $display("FAIL fetch_count: got %0d want 3840", fcount); end
  endtask
`endif
  initial begin
    test_reset;
    test_startup;
    test_full_frame;
    test_free_run;
    test_lock_drop;
    test_reset_mid;
`ifdef VGA_PREFETCH_EN
    test_prefetch;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
